// File: rtl/atoi_pkg.sv
// atoi_pkg: shared constants and state type for the decimal ASCII-to-integer
// converter (atoi32) and its multiply-accumulate helper (atoi_mac10).
package atoi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_NUL  = 8'h00;

  localparam int NDIG  = 10;  // characters per field
  localparam int ACC_W = 36;  // acc*10+9 always fits in 36 bits
  localparam int NUM_W = 32;

endpackage

// File: rtl/atoi_mac10.sv
// atoi_mac10: combinational acc*10 + digit.
//   acc   in  32  running value
//   digit in   4  decimal digit 0..9
//   sum   out 36  full-width result
//   ovf   out  1  result does not fit in 32 bits
module atoi_mac10
  import atoi_pkg::*;
(
  input  logic [NUM_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] acc_w;

  assign acc_w = {{(ACC_W-NUM_W){1'b0}}, acc};
  // x*10 as x*8 + x*2; no multiplier needed
  assign sum   = (acc_w << 3) + (acc_w << 1) + {{(ACC_W-4){1'b0}}, digit};
  assign ovf   = |sum[ACC_W-1:NUM_W];

endmodule

// File: rtl/atoi32.sv
// atoi32: iterative decimal ASCII-to-integer converter, one char per clock.
//   clk, reset      clock; synchronous active-high reset
//   load            start strobe; samples CHAR0..CHAR9 (CHAR0 most significant)
//   NUM             32-bit result, written only when a conversion completes
//   busy            high while converting
//   done            high from completion until next load/reset
//   err             non-digit (other than NUL) seen; valid while done
//   ovf             value exceeded 2^32-1; valid while done
module atoi32
  import atoi_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [7:0]       CHAR0,
  input  logic [7:0]       CHAR1,
  input  logic [7:0]       CHAR2,
  input  logic [7:0]       CHAR3,
  input  logic [7:0]       CHAR4,
  input  logic [7:0]       CHAR5,
  input  logic [7:0]       CHAR6,
  input  logic [7:0]       CHAR7,
  input  logic [7:0]       CHAR8,
  input  logic [7:0]       CHAR9,
  output logic [NUM_W-1:0] NUM,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ovf
);

  state_t            state;
  logic [NDIG*8-1:0] sreg;   // current char always in the top byte
  logic [3:0]        cnt;
  logic [NUM_W-1:0]  acc;

  logic [7:0]        cur;
  logic              is_dig;
  logic [ACC_W-1:0]  mac_sum;
  logic              mac_ovf;
  logic [NUM_W-1:0]  acc_nx;
  logic              err_nx, ovf_nx;

  assign cur    = sreg[NDIG*8-1 -: 8];
  assign is_dig = (cur >= ASCII_ZERO) && (cur <= ASCII_NINE);

  // for '0'..'9' the low nibble is the digit value
  atoi_mac10 u_mac (
    .acc   (acc),
    .digit (cur[3:0]),
    .sum   (mac_sum),
    .ovf   (mac_ovf)
  );

  always_comb begin
    acc_nx = acc;
    err_nx = err;
    ovf_nx = ovf;
    if (is_dig) begin
      // acc frozen once either flag is up
      if (!err && !ovf) begin
        if (mac_ovf) begin
          ovf_nx = 1'b1;
          acc_nx = '1;
        end else begin
          acc_nx = mac_sum[NUM_W-1:0];
        end
      end
    end else if (cur != ASCII_NUL) begin
      err_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      acc   <= '0;
      NUM   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      state <= CONV;
      sreg  <= {CHAR0, CHAR1, CHAR2, CHAR3, CHAR4,
                CHAR5, CHAR6, CHAR7, CHAR8, CHAR9};
      cnt   <= '0;
      acc   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        CONV: begin
          sreg <= sreg << 8;
          cnt  <= cnt + 4'd1;
          acc  <= acc_nx;
          err  <= err_nx;
          ovf  <= ovf_nx;
          if (cnt == 4'(NDIG-1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // err outranks ovf for the value; both flags still reported
            NUM   <= err_nx ? '0 : (ovf_nx ? '1 : acc_nx);
          end
        end
        default: ;  // IDLE and DONE hold everything
      endcase
    end
  end

endmodule

// File: tb/tb_atoi32.sv
// tb_atoi32: directed literal cases plus randomized loads/resets, checked
// every cycle against a behavioural model that computes each result with
// plain integer arithmetic at load time and releases it 10 cycles later.
module tb_atoi32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  ch [10];
  logic [31:0] NUM;
  logic        busy, done, err, ovf;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  atoi32 dut (
    .clk(clk), .reset(reset), .load(load),
    .CHAR0(ch[0]), .CHAR1(ch[1]), .CHAR2(ch[2]), .CHAR3(ch[3]), .CHAR4(ch[4]),
    .CHAR5(ch[5]), .CHAR6(ch[6]), .CHAR7(ch[7]), .CHAR8(ch[8]), .CHAR9(ch[9]),
    .NUM(NUM), .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void conv(output logic [31:0] n, output bit e, output bit o);
    longint a = 0;
    e = 0; o = 0;
    for (int i = 0; i < 10; i++) begin
      if (ch[i] >= 8'h30 && ch[i] <= 8'h39) begin
        if (!e && !o) begin
          a = a * 10 + longint'(ch[i] - 8'h30);
          if (a > 64'hFFFF_FFFF) o = 1;
        end
      end else if (ch[i] != 8'h00) begin
        e = 1;
      end
    end
    n = e ? 32'h0 : (o ? 32'hFFFF_FFFF : a[31:0]);
  endfunction

  logic [31:0] m_num = 0, p_num;
  bit m_busy = 0, m_done = 0, m_err = 0, m_ovf = 0, p_err, p_ovf;
  int left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_num = 0; m_busy = 0; m_done = 0; m_err = 0; m_ovf = 0; left = 0;
    end else if (load) begin
      conv(p_num, p_err, p_ovf);
      m_busy = 1; m_done = 0; left = 10;
    end else if (m_busy) begin
      left--;
      if (left == 0) begin
        m_busy = 0; m_done = 1;
        m_num = p_num; m_err = p_err; m_ovf = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_num", NUM, m_num);
      if (m_done) begin
        chk("model_err", 32'(err), 32'(m_err));
        chk("model_ovf", 32'(ovf), 32'(m_ovf));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_str(input string s);
    for (int i = 0; i < 10; i++) ch[i] = s[i];
  endtask

  // Called at a negedge with ch already set; ends at the negedge where done
  // first reads high.
  task automatic run(input string nm, input logic [31:0] en, input bit ee,
                     input bit eo, input logic [31:0] forbid);
    int nb = 0;
    bit fin = 0, seen = 0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk({nm, "_done_drop"}, 32'(done), 32'd0);
    for (int k = 0; k < 20; k++) begin
      if (NUM === forbid) seen = 1;
      if (done) begin fin = 1; break; end
      if (busy) nb++;
      @(negedge clk);
    end
    chk({nm, "_timeout"}, 32'(fin), 32'd1);
    chk({nm, "_busy_cycles"}, 32'(nb), 32'd10);
    chk({nm, "_num"}, NUM, en);
    chk({nm, "_err"}, 32'(err), 32'(ee));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
    chk({nm, "_busy_end"}, 32'(busy), 32'd0);
    chk({nm, "_forbidden_num"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 10; i++) ch[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_num", NUM, 32'h0);
    chk("rst_flags", {28'h0, busy, done, err, ovf}, 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    set_str("4294967295"); run("max", 32'hFFFF_FFFF, 0, 0, 32'hDEAD_BEEF);
    set_str("0000000123"); run("lead0", 32'h7B, 0, 0, 32'hDEAD_BEEF);
    for (int i = 0; i < 7; i++) ch[i] = 8'h00;
    run("nul123", 32'h7B, 0, 0, 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) ch[i] = 8'h00;
    run("allnul", 32'h0, 0, 0, 32'hDEAD_BEEF);
    set_str("4294967296"); run("ovf1", 32'hFFFF_FFFF, 0, 1, 32'hDEAD_BEEF);
    set_str("9999999999"); run("ovf9", 32'hFFFF_FFFF, 0, 1, 32'hDEAD_BEEF);
    set_str("00000A0001"); run("errA", 32'h0, 1, 0, 32'hDEAD_BEEF);
    // eight nines do not overflow before the 'A', so only err is raised
    set_str("99999999A9"); run("err9A", 32'h0, 1, 0, 32'hDEAD_BEEF);

    // restart mid-conversion; 500 must never appear
    set_str("0000000500");
    load = 1'b1; @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    set_str("0000000007"); run("restart", 32'd7, 0, 0, 32'd500);

    // reset mid-conversion
    set_str("4294967295");
    load = 1'b1; @(negedge clk); load = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("midrst_num", NUM, 32'h0);
    chk("midrst_flags", {28'h0, busy, done, err, ovf}, 32'h0);

    // back-to-back: second load on the cycle done first reads high
    set_str("0000000123"); run("b2b_a", 32'd123, 0, 0, 32'hDEAD_BEEF);
    set_str("0000000042"); run("b2b_b", 32'd42, 0, 0, 32'hDEAD_BEEF);

    // randomized phase: chars change every cycle, loads/resets at random
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 10; i++) begin
        int r = $urandom_range(99);
        if (r < 60)      ch[i] = 8'h30 + 8'($urandom_range(9));
        else if (r < 75) ch[i] = 8'h00;
        else if (r < 92) ch[i] = 8'h39;
        else             ch[i] = 8'($urandom_range(255));
      end
      load  = ($urandom_range(done ? 2 : 14) == 0);
      reset = ($urandom_range(299) == 0);
      @(negedge clk);
    end
    load = 1'b0; reset = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
